// File: rtl/fetch_sequencer.sv
// Program-counter and instruction-fetch sequencer: one outstanding imem request,
// valid/ready hand-off to decode, redirects override sequential fetch.
module fetch_sequencer #(
    parameter int                    ADDR_WIDTH = 12,
    parameter int                    OFFSET     = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [31:0]           imem_rdata,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  if_valid,
    input  logic                  if_ready,
    output logic [31:0]           if_instr,
    output logic [ADDR_WIDTH-1:0] if_pc,
    output logic [ADDR_WIDTH-1:0] if_incpc,
    output logic                  busy
);

    typedef enum logic [1:0] {
        S_BOOT,
        S_FETCH,
        S_DRAIN,
        S_HOLD
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pending;
    logic [ADDR_WIDTH-1:0] redir_tgt;
    logic [ADDR_WIDTH-1:0] pc_inc;
    logic [ADDR_WIDTH-1:0] drain_tgt;

    always_comb begin
        redir_tgt = redirect_pc & ~ADDR_WIDTH'(3);
        pc_inc    = pc + ADDR_WIDTH'(OFFSET);
        // a redirect landing on the stale ack beats the stored target
        drain_tgt = redirect_valid ? redir_tgt : pending;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_BOOT;
            pc        <= RESET_PC;
            pending   <= '0;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
            busy      <= 1'b0;
            if_valid  <= 1'b0;
            if_instr  <= '0;
            if_pc     <= '0;
            if_incpc  <= '0;
        end else begin
            case (state)
                S_BOOT: begin
                    state    <= S_FETCH;
                    imem_req <= 1'b1;
                    busy     <= 1'b1;
                    if (redirect_valid) begin
                        pc        <= redir_tgt;
                        imem_addr <= redir_tgt;
                    end else begin
                        imem_addr <= pc;
                    end
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        if (redirect_valid) begin
                            // request stays high; the new address goes out next cycle
                            pc        <= redir_tgt;
                            imem_addr <= redir_tgt;
                        end else begin
                            if_instr <= imem_rdata;
                            if_pc    <= pc;
                            if_incpc <= pc_inc;
                            pc       <= pc_inc;
                            if_valid <= 1'b1;
                            imem_req <= 1'b0;
                            busy     <= 1'b0;
                            state    <= S_HOLD;
                        end
                    end else if (redirect_valid) begin
                        pending <= redir_tgt;
                        state   <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (imem_ack) begin
                        pc        <= drain_tgt;
                        imem_addr <= drain_tgt;
                        state     <= S_FETCH;
                    end else if (redirect_valid) begin
                        pending <= redir_tgt;
                    end
                end
                S_HOLD: begin
                    if (redirect_valid) begin
                        if_valid  <= 1'b0;
                        pc        <= redir_tgt;
                        imem_addr <= redir_tgt;
                        imem_req  <= 1'b1;
                        busy      <= 1'b1;
                        state     <= S_FETCH;
                    end else if (if_ready) begin
                        if_valid  <= 1'b0;
                        imem_addr <= pc;
                        imem_req  <= 1'b1;
                        busy      <= 1'b1;
                        state     <= S_FETCH;
                    end
                end
                default: state <= S_BOOT;
            endcase
        end
    end

endmodule
